// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch debouncer with press/release, long-press and auto-repeat ticks
module debounce_multi #(
  parameter int N             = 5,
  parameter int DB_CYCLES     = 2000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] switch,
  output logic [N-1:0] db,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic [N-1:0] hold_tick,
  output logic [N-1:0] rpt_tick,
  output logic [N-1:0] long_press,
  output logic         any_rise
);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DB_CYCLES);
  localparam int HW = $clog2(HMAX > 2 ? HMAX : 2);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST = HW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  localparam logic [1:0] ZERO = 2'd0, WAIT1 = 2'd1, ONE = 2'd2, WAIT0 = 2'd3;
  logic [N-1:0] meta, sync, rise_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta <= '0;
      sync <= '0;
      any_rise <= 1'b0;
    end else begin
      meta <= switch;
      sync <= meta;
      any_rise <= |rise_n;
    end
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0] st, st_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt, hcnt_n, rcnt, rcnt_n;
    logic db_q, db_n, lp_q, lp_n, rise_q, rise_c, fall_q, fall_n, hold_q, hold_n, rpt_q, rpt_n;
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      hcnt_n = hcnt;
      rcnt_n = rcnt;
      db_n = db_q;
      lp_n = lp_q;
      rise_c = 1'b0;
      fall_n = 1'b0;
      hold_n = 1'b0;
      rpt_n = 1'b0;
      case (st)
        ZERO: if (sync[i]) begin
          st_n = WAIT1;
          cnt_n = '0;
        end
        WAIT1: if (!sync[i]) st_n = ZERO;
        else if (cnt == DB_LAST) begin
          st_n = ONE;
          db_n = 1'b1;
          rise_c = 1'b1;
          hcnt_n = '0;
        end else cnt_n = cnt + 1'b1;
        ONE: begin
          if (!sync[i]) begin
            st_n = WAIT0;
            cnt_n = '0;
          end
          // the cycle that leaves ONE still counts toward the press duration
          if (!lp_q) begin
            if (hcnt == HOLD_LAST) begin
              hold_n = 1'b1;
              lp_n = 1'b1;
              rcnt_n = '0;
            end else hcnt_n = hcnt + 1'b1;
          end else if (REPEAT_CYCLES > 0) begin
            rpt_n = rcnt == RPT_LAST;
            rcnt_n = (rcnt == RPT_LAST) ? '0 : rcnt + 1'b1;
          end
        end
        default: if (sync[i]) st_n = ONE;
        else if (cnt == DB_LAST) begin
          st_n = ZERO;
          db_n = 1'b0;
          fall_n = 1'b1;
          lp_n = 1'b0;
          hcnt_n = '0;
          rcnt_n = '0;
        end else cnt_n = cnt + 1'b1;
      endcase
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= ZERO;
        cnt <= '0;
        hcnt <= '0;
        rcnt <= '0;
        {db_q, lp_q, rise_q, fall_q, hold_q, rpt_q} <= '0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        hcnt <= hcnt_n;
        rcnt <= rcnt_n;
        {db_q, lp_q, rise_q, fall_q, hold_q, rpt_q} <= {db_n, lp_n, rise_c, fall_n, hold_n, rpt_n};
      end
    assign rise_n[i] = rise_c;
    assign {db[i], long_press[i], rise_tick[i], fall_tick[i], hold_tick[i], rpt_tick[i]} =
           {db_q, lp_q, rise_q, fall_q, hold_q, rpt_q};
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: randomized and directed checks of debounce_multi against a run-length reference model
module tb_debounce_multi;
  localparam int DB = 4, H = 10, R = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] sw_a = '0;
  logic [0:0] sw_b = '0;
  logic [1:0] db_a, rise_a, fall_a, hold_a, rpt_a, lp_a;
  logic [0:0] db_b, rise_b, fall_b, hold_b, rpt_b, lp_b;
  logic any_a, any_b;
  int checks = 0, errors = 0, cyc = 0, rise_at = 0;
  bit m_s1[3], m_s2[3], m_db[3], m_rise[3], m_fall[3], m_hold[3], m_rpt[3], m_s;
  int m_run[3], m_ones[3];
  int rep[3] = '{R, R, 0};
  always #5 clk = ~clk;
  debounce_multi #(.N(2), .DB_CYCLES(DB), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut_a (
    .clk(clk), .reset(reset), .switch(sw_a), .db(db_a), .rise_tick(rise_a), .fall_tick(fall_a),
    .hold_tick(hold_a), .rpt_tick(rpt_a), .long_press(lp_a), .any_rise(any_a));
  debounce_multi #(.N(1), .DB_CYCLES(DB), .HOLD_CYCLES(H), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .switch(sw_b), .db(db_b), .rise_tick(rise_b), .fall_tick(fall_b),
    .hold_tick(hold_b), .rpt_tick(rpt_b), .long_press(lp_b), .any_rise(any_b));
  wire [12:0] obs_a = {db_a, rise_a, fall_a, hold_a, rpt_a, lp_a, any_a};
  wire [6:0] obs_b = {db_b, rise_b, fall_b, hold_b, rpt_b, lp_b, any_b};
  // db flips once the synchronised input has disagreed with it for DB+1 sampled edges;
  // press duration counts edges spent stable-high, so bounce time in release is excluded
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        {m_s1[c], m_s2[c], m_db[c], m_rise[c], m_fall[c], m_hold[c], m_rpt[c]} = '0;
        m_run[c] = 0;
        m_ones[c] = 0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_s = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = (c < 2) ? sw_a[c] : sw_b[0];
        {m_rise[c], m_fall[c], m_hold[c], m_rpt[c]} = '0;
        if (m_db[c] && m_run[c] == 0) begin
          m_ones[c]++;
          if (m_ones[c] == H) m_hold[c] = 1;
          else if (rep[c] > 0 && m_ones[c] > H) m_rpt[c] = ((m_ones[c] - H) % rep[c]) == 0;
        end
        if (m_s != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_db[c] = m_s;
            m_run[c] = 0;
            m_ones[c] = 0;
            if (m_s) m_rise[c] = 1;
            else m_fall[c] = 1;
          end
        end else m_run[c] = 0;
      end
    end
  end
  function automatic logic [12:0] exp_a();
    logic [1:0] d, r, f, h, p, l;
    for (int c = 0; c < 2; c++) begin
      d[c] = m_db[c]; r[c] = m_rise[c]; f[c] = m_fall[c]; h[c] = m_hold[c]; p[c] = m_rpt[c];
      l[c] = m_db[c] && m_ones[c] >= H;
    end
    return {d, r, f, h, p, l, r[0] | r[1]};
  endfunction
  function automatic logic [6:0] exp_b();
    return {m_db[2], m_rise[2], m_fall[2], m_hold[2], m_rpt[2], m_db[2] && m_ones[2] >= H, m_rise[2]};
  endfunction
  task automatic cycle(input logic [1:0] a, input logic b);
    @(negedge clk);
    sw_a = a;
    sw_b[0] = b;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b0);
    checks++;
    if (obs_a !== 13'd0 || obs_b !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got a=%b b=%b want all zero", obs_a, obs_b);
    end
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_clean_press();
    int k, nrise = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(2'b01, 1'b0);
      if (i == 0) k = cyc;
      checks++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        errors++;
        $display("FAIL clean_press cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a(), exp_b());
      end
      if (rise_a[0]) begin nrise++; rise_at = cyc; end
    end
    checks++;
    if (rise_at != k + 6 || nrise != 1) begin
      errors++;
      $display("FAIL clean_press_latency got rise@%0d x%0d want rise@%0d x1", rise_at, nrise, k + 6);
    end
  endtask
  task automatic test_long_press();
    int hold_at = -1, r1 = -1, r2 = -1, rel_k = 0, fall_at = -1;
    logic fall_lp = 1'bx;
    for (int i = 0; i < 20; i++) begin
      cycle(2'b01, 1'b0);
      checks++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        errors++;
        $display("FAIL long_press cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a(), exp_b());
      end
      if (hold_a[0]) hold_at = cyc;
      if (rpt_a[0] && r1 < 0) r1 = cyc;
      else if (rpt_a[0] && r2 < 0) r2 = cyc;
    end
    checks++;
    if (hold_at - rise_at != H || r1 - hold_at != R || r2 - r1 != R) begin
      errors++;
      $display("FAIL hold_repeat_timing got hold+%0d rpt+%0d rpt+%0d want +%0d +%0d +%0d",
               hold_at - rise_at, r1 - hold_at, r2 - r1, H, R, R);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(2'b00, 1'b0);
      if (i == 0) rel_k = cyc;
      checks++;
      if (obs_a !== exp_a()) begin
        errors++;
        $display("FAIL release cyc=%0d got a=%b want a=%b", cyc, obs_a, exp_a());
      end
      if (fall_a[0]) begin fall_at = cyc; fall_lp = lp_a[0]; end
    end
    checks++;
    if (fall_at != rel_k + 6 || fall_lp !== 1'b0) begin
      errors++;
      $display("FAIL release_timing got fall@%0d lp=%b want fall@%0d lp=0", fall_at, fall_lp, rel_k + 6);
    end
  endtask
  task automatic test_bounce();
    logic [1:0] pat[12] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    int nt = 0, k = 0, r_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(pat[i], 1'b0);
      checks++;
      if (obs_a !== exp_a()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got a=%b want a=%b", cyc, obs_a, exp_a());
      end
      nt += int'(db_a[0]) + int'(rise_a[0]) + int'(fall_a[0]);
    end
    checks++;
    if (nt != 0) begin
      errors++;
      $display("FAIL bounce_reject got %0d db/tick cycles want 0", nt);
    end
    for (int i = 0; i < 9; i++) begin
      cycle(2'b01, 1'b0);
      if (i == 0) k = cyc;
      if (rise_a[0]) r_at = cyc;
    end
    checks++;
    if (r_at != k + 6) begin
      errors++;
      $display("FAIL bounce_then_hold got rise@%0d want rise@%0d", r_at, k + 6);
    end
    for (int i = 0; i < 10; i++) cycle(2'b00, 1'b0);
  endtask
  task automatic test_release_glitch();
    int k = 0, r_at = -1, h_at = -1, nf = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(2'b01, 1'b0);
      if (i == 0) k = cyc;
      if (rise_a[0]) r_at = cyc;
    end
    cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b0);
    for (int i = 0; i < 25; i++) begin
      cycle(2'b01, 1'b0);
      checks++;
      if (obs_a !== exp_a()) begin
        errors++;
        $display("FAIL glitch cyc=%0d got a=%b want a=%b", cyc, obs_a, exp_a());
      end
      if (hold_a[0]) h_at = cyc;
      nf += int'(fall_a[0]);
    end
    checks++;
    if (r_at != k + 6 || h_at - r_at != H + 2 || nf != 0) begin
      errors++;
      $display("FAIL glitch_hold_delay got rise@%0d hold+%0d falls=%0d want rise@%0d hold+%0d falls=0",
               r_at, h_at - r_at, nf, k + 6, H + 2);
    end
    for (int i = 0; i < 10; i++) cycle(2'b00, 1'b0);
  endtask
  task automatic test_no_repeat();
    int nh = 0, nr = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(2'b00, 1'b1);
      checks++;
      if (obs_b !== exp_b()) begin
        errors++;
        $display("FAIL no_repeat cyc=%0d got b=%b want b=%b", cyc, obs_b, exp_b());
      end
      nh += int'(hold_b[0]);
      nr += int'(rpt_b[0]);
    end
    checks++;
    if (nh != 1 || nr != 0 || lp_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL no_repeat_counts got hold=%0d rpt=%0d lp=%b want hold=1 rpt=0 lp=1", nh, nr, lp_b[0]);
    end
    for (int i = 0; i < 10; i++) cycle(2'b00, 1'b0);
  endtask
  task automatic test_simul_reset();
    int k = 0, r_at = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(2'b11, 1'b0);
      if (i == 0) k = cyc;
      if (rise_a === 2'b11 && any_a) r_at = cyc;
    end
    checks++;
    if (r_at != k + 6) begin
      errors++;
      $display("FAIL simultaneous_rise got both@%0d want both@%0d", r_at, k + 6);
    end
    for (int i = 0; i < 10; i++) cycle(2'b10, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'b11, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_a !== 13'd0 || obs_b !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got a=%b b=%b want all zero", obs_a, obs_b);
    end
    cycle(2'b11, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc;
    r_at = -1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a(), exp_b());
      end
      if (rise_a[0] && r_at < 0) r_at = cyc;
      cycle(2'b11, 1'b0);
    end
    checks++;
    if (r_at != k + 6) begin
      errors++;
      $display("FAIL post_reset_rise got rise@%0d want rise@%0d", r_at, k + 6);
    end
  endtask
  task automatic test_random();
    logic [2:0] tgt = 3'b011, sw;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 99) < 4) tgt[c] = ~tgt[c];
        sw[c] = ($urandom_range(0, 99) < 12) ? ~tgt[c] : tgt[c];
      end
      cycle(sw[1:0], sw[2]);
      checks++;
      if (obs_a !== exp_a() || obs_b !== exp_b()) begin
        errors++;
        $display("FAIL random cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a(), exp_b());
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_long_press();
    test_bounce();
    test_release_glitch();
    test_no_repeat();
    test_simul_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
